sfp_seq_ctrl: RTL
=================

// Module: sfp_seq_ctrl
// PURPOSE
//   Sequencer for the 8-row SFP (special-function) array. One start pulse runs a
//   full job: per-row ADD (accumulate) sweep, then per-row DIV (normalize) sweep,
//   then streams each row's result out over a valid/ready port.
//   Drives the array's inst bus and reads back its muxed sfp_out. Sits between
//   the core control FSM and the SFP array.
// PARAMETERS
//   col      8              number of SFP rows sequenced
//   bw       8              activation width
//   bw_psum  2*bw+4         psum/result width
//   OPW      5              op-field width; must satisfy 2*col <= 2**OPW-1
//   IDXW     3              read-index width; must satisfy col <= 2**IDXW
// PORTS
//   clk        in   1             clock
//   reset      in   1             synchronous, active-high reset
//   start      in   1             job request; sampled only in IDLE
//   busy       out  1             job in progress (ADD..READ states)
//   done       out  1             one-cycle pulse after last row is read out
//   inst       out  OPW+IDXW      to SFP array: [OPW-1:0]=op, [OPW+IDXW-1:OPW]=rd idx
//   sfp_rd     in   bw_psum       SFP array sfp_out (row selected by inst rd idx)
//   out_valid  out  1             result row valid
//   out_ready  in   1             downstream accepts result
//   out_data   out  bw_psum       = sfp_rd while out_valid, else 0
//   out_idx    out  IDXW          row index of out_data
//   cycle_cnt  out  16            job cycle count (SFP_CTRL_PERF_EN only)
// BEHAVIOUR
//   - Op encoding: 0 = NOP; r+1 = ADD on row r; col+r+1 = DIV on row r (r = 0..col-1).
//   - inst, busy, done, out_valid are registered; out_data is combinational from sfp_rd.
//   - FSM:
//       IDLE  -> ADD on start.
//       ADD   one cycle per row, r = 0..col-1; op = r+1; -> SET1 after r = col-1.
//       SET1  one cycle, op = 0 (lets last ADD land) -> DIV.
//       DIV   one cycle per row, op = col+r+1; -> SET2 after r = col-1.
//       SET2  one cycle, op = 0 -> READ.
//       READ  op = 0, rd idx = r, out_valid = 1. r advances only on out_valid & out_ready.
//             -> DONE after r = col-1 handshakes.
//       DONE  done = 1 for one cycle, busy = 0 -> IDLE.
//   - Timing, ready held high, col = 8: start at cycle T.
//       T+1..T+8   ADD ops 1..8
//       T+9        NOP (SET1)
//       T+10..T+17 DIV ops 9..16
//       T+18       NOP (SET2)
//       T+19..T+26 READ, out_idx 0..7
//       T+27       done
//   - busy = 1 from T+1 through the last READ cycle.
//   - READ stall: with out_ready = 0, rd idx, out_idx and out_valid hold; sfp_rd must not
//     change, since the array is given op = 0.
//   - start is ignored outside IDLE, including in the DONE cycle. No queueing.
//   - Reset at any point (mid-sweep or mid-READ): next cycle state = IDLE, r = 0,
//     inst = 0, busy = 0, done = 0, out_valid = 0, out_idx = 0, cycle_cnt = 0.
//     A partial job is abandoned; the array must be reset alongside.
//   - Row counter r is IDXW+1 bits wide. The terminal test is r == col-1, so there is
//     no wrap for col = 2**IDXW.
// CONFIGURATION
//   SFP_CTRL_PERF_EN defined:
//     - cycle_cnt clears on the accepted start.
//     - Increments every busy cycle; saturates at 16'hFFFF.
//     - Holds its value through DONE/IDLE until the next start.
//     - For the timing above it reads 26 in the done cycle.
//   SFP_CTRL_PERF_EN undefined:
//     - cycle_cnt is tied to 0.
//     - No counter flops are synthesized.
// TESTING
//   1 Reset, then idle 5 cycles -> inst = 0, busy = 0, done = 0, out_valid = 0 throughout.
//   2 start at T, out_ready = 1 -> ops 1..8, 0, 9..16, 0 on T+1..T+18;
//     out_idx 0..7 on T+19..T+26; done only at T+27.
//     Model rows give out_data = each row's sum / normalizer.
//   3 out_ready = 0 for 3 cycles at out_idx = 2 -> idx/data/valid held stable,
//     then idx 3 follows the first accepted handshake; done delayed by 3 cycles.
//   4 start re-pulsed at T+5 and at T+27 -> ignored: single job, a single done,
//     still IDLE at T+28.
//   5 reset asserted at T+12 (mid-DIV) -> at T+13 IDLE with all outputs 0;
//     new start at T+15 runs a clean full job.
//   6 PERF_EN build, job with 4 total stall cycles -> cycle_cnt = 30 in the done cycle;
//     non-PERF build -> cycle_cnt = 0.

Source files
------------

// File: rtl/sfp_seq_ctrl.sv
// sfp_seq_ctrl: job sequencer for the 8-row SFP array.
// One start pulse runs an ADD sweep, then a DIV sweep, then streams each row's
// result out over a valid/ready port and pulses done.
// Optional build macro SFP_CTRL_PERF_EN adds the 16-bit saturating job cycle counter;
// without it cycle_cnt is tied to zero.
module sfp_seq_ctrl #(
    parameter int col     = 8,
    parameter int bw      = 8,
    parameter int bw_psum = 2*bw+4,
    parameter int OPW     = 5,
    parameter int IDXW    = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic [OPW+IDXW-1:0] inst,
    input  logic [bw_psum-1:0]  sfp_rd,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [bw_psum-1:0]  out_data,
    output logic [IDXW-1:0]     out_idx,
    output logic [15:0]         cycle_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADD,
        S_SET1,
        S_DIV,
        S_SET2,
        S_READ,
        S_DONE
    } state_t;

    // r is one bit wider than the row index so col = 2**IDXW never wraps
    localparam logic [IDXW:0]  R_LAST   = (IDXW+1)'(col - 1);
    localparam logic [OPW-1:0] DIV_BASE = OPW'(col + 1);

    state_t                state_q, state_d;
    logic [IDXW:0]         r_q, r_d;
    logic [OPW+IDXW-1:0]   inst_q, inst_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  valid_q, valid_d;
    logic [IDXW-1:0]       idx_q, idx_d;

    // State, row counter and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            r_q     <= '0;
            inst_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            inst_q  <= inst_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
        end
    end

    // Next state and row counter
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ADD;
                    r_d     = '0;
                end
            end
            S_ADD: begin
                if (r_q == R_LAST) begin
                    state_d = S_SET1;
                    r_d     = '0;
                end else begin
                    r_d = r_q + 1'b1;
                end
            end
            S_SET1: begin
                state_d = S_DIV;
                r_d     = '0;
            end
            S_DIV: begin
                if (r_q == R_LAST) begin
                    state_d = S_SET2;
                    r_d     = '0;
                end else begin
                    r_d = r_q + 1'b1;
                end
            end
            S_SET2: begin
                state_d = S_READ;
                r_d     = '0;
            end
            S_READ: begin
                if (valid_q && out_ready) begin
                    if (r_q == R_LAST) begin
                        state_d = S_DONE;
                        r_d     = '0;
                    end else begin
                        r_d = r_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                r_d     = '0;
            end
            default: begin
                state_d = S_IDLE;
                r_d     = '0;
            end
        endcase
    end

    // Outputs decoded from the next state so they appear registered in that state's cycle
    always_comb begin
        inst_d  = '0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        valid_d = 1'b0;
        idx_d   = '0;
        case (state_d)
            S_ADD: begin
                inst_d[OPW-1:0] = OPW'(r_d) + OPW'(1);
                busy_d          = 1'b1;
            end
            S_DIV: begin
                inst_d[OPW-1:0] = OPW'(r_d) + DIV_BASE;
                busy_d          = 1'b1;
            end
            S_SET1, S_SET2: begin
                busy_d = 1'b1;
            end
            S_READ: begin
                inst_d[OPW+IDXW-1:OPW] = r_d[IDXW-1:0];
                busy_d                 = 1'b1;
                valid_d                = 1'b1;
                idx_d                  = r_d[IDXW-1:0];
            end
            S_DONE: begin
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    assign inst      = inst_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign out_valid = valid_q;
    assign out_idx   = idx_q;
    assign out_data  = valid_q ? sfp_rd : '0;

`ifdef SFP_CTRL_PERF_EN
    logic [15:0] cnt_q, cnt_d;

    // Cleared on accepted start, counts busy cycles, saturates, holds when idle
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == S_IDLE && start) begin
            cnt_d = '0;
        end else if (busy_q && cnt_q != '1) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Cycle counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cycle_cnt = cnt_q;
`else
    assign cycle_cnt = '0;
`endif

endmodule
